// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response handshake between the core controller and
// the ALU sequencer.
//   req_valid/req_ready   operation request handshake
//   req_func/op1/op2      function code and signed operands
//   rsp_valid/rsp_ready   response handshake
//   rsp_result/flags/err  captured result, {overflow, equals, above, zero}, reject flag
// master: core controller side. slave: alu_sequencer side.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_func;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_error;

  modport master (
    output req_valid, req_func, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error
  );

  modport slave (
    input  req_valid, req_func, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_error
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one operation at a time to the combinational ALU and
// returns its result and flags.
//   clock, reset   single clock, synchronous active-high reset
//   bus            request/response handshake (slave side)
//   alu_op1/op2    operands driven to the ALU
//   alu_func       function code driven to the ALU (FUNC_IDLE unless firing)
//   alu_result     ALU result input
//   alu_overflow/equals/above/zero  ALU flags, passed through unmodified
//
// state | meaning
// IDLE  | waiting for a request
// LOAD  | operands on the ALU, func held at FUNC_IDLE
// FIRE  | latched func on the ALU for SETTLE_CYCLES cycles
// RESP  | response held until rsp_ready
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [5:0]  FUNC_IDLE     = 6'b000000
) (
  input  logic                clock,
  input  logic                reset,
  alu_sequencer_if.slave      bus,
  output logic [31:0]         alu_op1,
  output logic [31:0]         alu_op2,
  output logic [5:0]          alu_func,
  input  logic [31:0]         alu_result,
  input  logic                alu_overflow,
  input  logic                alu_equals,
  input  logic                alu_above,
  input  logic                alu_zero
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIRE, S_RESP} state_t;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_DIV = 6'b011010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOT = 6'b100111;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [5:0]  func_q;
  logic [5:0]  alu_func_q;
  logic [31:0] op1_q, op2_q;
  logic [3:0]  cnt_q;
  logic        rsp_valid_q, rsp_error_q;
  logic [31:0] rsp_result_q;
  logic [3:0]  rsp_flags_q;

  logic supported_d;
  logic div_zero_d;

  always_comb begin
    supported_d = 1'b0;
    case (bus.req_func)
      F_ADD, F_SUB, F_MUL, F_DIV, F_AND, F_OR, F_NOT: supported_d = 1'b1;
      default:                                         supported_d = 1'b0;
    endcase
  end

  assign div_zero_d = (bus.req_func == F_DIV) && (bus.req_op2 == 32'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      func_q       <= FUNC_IDLE;
      alu_func_q   <= FUNC_IDLE;
      op1_q        <= '0;
      op2_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // req_ready is implied here: state is IDLE and reset is low.
          if (bus.req_valid) begin
            func_q <= bus.req_func;
            op1_q  <= bus.req_op1;
            op2_q  <= bus.req_op2;
            if (!supported_d) begin
              rsp_valid_q  <= 1'b1;
              rsp_error_q  <= 1'b1;
              rsp_result_q <= '0;
              rsp_flags_q  <= 4'b0000;
              state_q      <= S_RESP;
            end else if (div_zero_d) begin
              rsp_valid_q  <= 1'b1;
              rsp_error_q  <= 1'b1;
              rsp_result_q <= '0;
              rsp_flags_q  <= 4'b1000;
              state_q      <= S_RESP;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          cnt_q      <= CNT_INIT;
          alu_func_q <= func_q;
          state_q    <= S_FIRE;
        end
        S_FIRE: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q  <= 1'b1;
            rsp_error_q  <= 1'b0;
            rsp_result_q <= alu_result;
            rsp_flags_q  <= {alu_overflow, alu_equals, alu_above, alu_zero};
            alu_func_q   <= FUNC_IDLE;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE) && !reset;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign alu_op1        = op1_q;
  assign alu_op2        = op2_q;
  assign alu_func       = alu_func_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed-vector bench for alu_sequencer with a small
// behavioural ALU model on the ALU side.
module tb_alu_sequencer;

  localparam int         SETTLE = 1;
  localparam logic [5:0] F_IDLE = 6'b000000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_MUL  = 6'b011000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_BAD  = 6'b000001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [5:0]  alu_func;
  logic        alu_overflow, alu_equals, alu_above, alu_zero;

  int checks = 0;
  int errors = 0;

  alu_sequencer_if bus ();

  alu_sequencer #(.SETTLE_CYCLES(SETTLE), .FUNC_IDLE(F_IDLE)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_func     (alu_func),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_equals   (alu_equals),
    .alu_above    (alu_above),
    .alu_zero     (alu_zero)
  );

  always #5 clock = ~clock;

  // Behavioural ALU: responds combinationally to whatever func is driven.
  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    case (alu_func)
      F_ADD: begin
        alu_result   = alu_op1 + alu_op2;
        alu_overflow = (alu_op1[31] == alu_op2[31]) && (alu_result[31] != alu_op1[31]);
      end
      F_SUB: begin
        alu_result   = alu_op1 - alu_op2;
        alu_overflow = (alu_op1[31] != alu_op2[31]) && (alu_result[31] != alu_op1[31]);
      end
      F_MUL:     alu_result = alu_op1 * alu_op2;
      F_DIV:     alu_result = (alu_op2 != 0) ? 32'($signed(alu_op1) / $signed(alu_op2)) : 32'd0;
      6'b100100: alu_result = alu_op1 & alu_op2;
      6'b100101: alu_result = alu_op1 | alu_op2;
      6'b100111: alu_result = ~alu_op1;
      default:   alu_result = 32'd0;
    endcase
    alu_equals = (alu_op1 == alu_op2);
    alu_above  = ($signed(alu_op1) > $signed(alu_op2));
    alu_zero   = (alu_result == 32'd0);
  end

  // Tracks the shortest run of FUNC_IDLE cycles seen between two FIRE windows.
  int idle_run  = 0;
  int min_gap   = 999;
  bit fire_seen = 1'b0;
  always @(negedge clock) begin
    if (alu_func == F_IDLE) begin
      idle_run++;
    end else begin
      if (fire_seen && idle_run > 0 && idle_run < min_gap) min_gap = idle_run;
      if (idle_run > 0) fire_seen = 1'b1;
      idle_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge. Returns on the negedge where rsp_valid is first seen
  // (or after a timeout), with latency counted in cycles after acceptance.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int fire_cnt);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_func  = f;
    bus.req_op1   = a;
    bus.req_op2   = b;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat      = 0;
    fire_cnt = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (alu_func == f) fire_cnt++;
      if (bus.rsp_valid) break;
    end
  endtask

  // Passes the handshake edge (rsp_ready assumed high) and checks the drop.
  task automatic consume(input string tag);
    @(negedge clock);
    check(tag, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int lat, fc, stray;
    bus.req_valid = 1'b0;
    bus.req_func  = 6'd0;
    bus.req_op1   = 32'd0;
    bus.req_op2   = 32'd0;
    bus.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    check("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_alu_func", 32'(alu_func), 32'(F_IDLE));
    check("rst_alu_op1", alu_op1, 32'd0);
    check("rst_alu_op2", alu_op2, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // ADD 7 + 5
    run_op(F_ADD, 32'd7, 32'd5, lat, fc);
    check("add_latency", 32'(lat), 32'(SETTLE + 2));
    check("add_result", bus.rsp_result, 32'd12);
    check("add_error", 32'(bus.rsp_error), 32'd0);
    check("add_flags", 32'(bus.rsp_flags), 32'b0010);
    check("add_fire_cycles", 32'(fc), 32'(SETTLE));
    check("add_op1_hold", alu_op1, 32'd7);
    check("add_op2_hold", alu_op2, 32'd5);
    check("add_func_in_resp", 32'(alu_func), 32'(F_IDLE));
    consume("add_consume");

    // Back-to-back ADDs
    fire_seen = 1'b0;
    min_gap   = 999;
    run_op(F_ADD, 32'd3, 32'd4, lat, fc);
    check("b2b1_result", bus.rsp_result, 32'd7);
    check("b2b1_flags", 32'(bus.rsp_flags), 32'b0000);
    consume("b2b1_consume");
    run_op(F_ADD, 32'd10, 32'd20, lat, fc);
    check("b2b2_result", bus.rsp_result, 32'd30);
    check("b2b2_latency", 32'(lat), 32'(SETTLE + 2));
    check("b2b_idle_gap_ge3", 32'(min_gap >= 3 && min_gap < 999), 32'd1);
    consume("b2b2_consume");

    // Signed overflow on ADD
    run_op(F_ADD, 32'h7FFF_FFFF, 32'd1, lat, fc);
    check("ovf_result", bus.rsp_result, 32'h8000_0000);
    check("ovf_flags", 32'(bus.rsp_flags), 32'b1010);
    consume("ovf_consume");

    // DIV 9 / 0
    run_op(F_DIV, 32'd9, 32'd0, lat, fc);
    check("div0_latency", 32'(lat), 32'd1);
    check("div0_error", 32'(bus.rsp_error), 32'd1);
    check("div0_result", bus.rsp_result, 32'd0);
    check("div0_flags", 32'(bus.rsp_flags), 32'b1000);
    check("div0_func_never", 32'(fc), 32'd0);
    consume("div0_consume");

    // Unsupported func
    run_op(F_BAD, 32'd1, 32'd2, lat, fc);
    check("bad_latency", 32'(lat), 32'd1);
    check("bad_error", 32'(bus.rsp_error), 32'd1);
    check("bad_result", bus.rsp_result, 32'd0);
    check("bad_flags", 32'(bus.rsp_flags), 32'b0000);
    check("bad_func_idle", 32'(alu_func), 32'(F_IDLE));
    consume("bad_consume");

    // SUB 5 - 5 with back-pressure
    bus.rsp_ready = 1'b0;
    run_op(F_SUB, 32'd5, 32'd5, lat, fc);
    check("sub_latency", 32'(lat), 32'(SETTLE + 2));
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_result", bus.rsp_result, 32'd0);
      check("stall_flags", 32'(bus.rsp_flags), 32'b0101);
      check("stall_error", 32'(bus.rsp_error), 32'd0);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    consume("sub_consume");

    // Reset during FIRE
    bus.req_valid = 1'b1;
    bus.req_func  = F_SUB;
    bus.req_op1   = 32'd8;
    bus.req_op2   = 32'd3;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    @(negedge clock);
    check("abort_load_func", 32'(alu_func), 32'(F_IDLE));
    @(negedge clock);
    check("abort_fire_func", 32'(alu_func), 32'(F_SUB));
    reset = 1'b1;
    @(negedge clock);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_func_idle", 32'(alu_func), 32'(F_IDLE));
    check("abort_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("abort_idle_ready", 32'(bus.req_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid) stray++;
      @(negedge clock);
    end
    check("abort_no_response", 32'(stray), 32'd0);

    // MUL 6 * 7 after abort
    run_op(F_MUL, 32'd6, 32'd7, lat, fc);
    check("mul_latency", 32'(lat), 32'(SETTLE + 2));
    check("mul_result", bus.rsp_result, 32'd42);
    check("mul_error", 32'(bus.rsp_error), 32'd0);
    check("mul_flags", 32'(bus.rsp_flags), 32'b0000);
    consume("mul_consume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
